// File: rtl/wb_bram_pkg.sv
// wb_bram_pkg: shared types and constants for the Wishbone BRAM controller.
//   state_t     - controller FSM states (ST_PREF only reachable when the
//                 WB_BRAM_PREFETCH_EN build option is defined)
//   ADDR_HI_DEF - default wbs_adr_i[31:20] value of the BRAM window
//   CNT_W       - wait counter width (covers DELAYS up to 15)
package wb_bram_pkg;

   localparam logic [11:0] ADDR_HI_DEF = 12'h380;
   localparam int          CNT_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_PREF = 2'd3
   } state_t;

endpackage

// File: rtl/wb_bram_ctrl_if.sv
// wb_bram_ctrl_if: Wishbone classic slave bus between the user-project port
// and the BRAM controller.
//   wbs_cyc_i/wbs_stb_i/wbs_we_i  cycle, strobe, write enable (master -> slave)
//   wbs_sel_i[3:0]                byte selects
//   wbs_adr_i[31:0]               byte address
//   wbs_dat_i[31:0]               write data
//   wbs_ack_o                     one-cycle ack (slave -> master)
//   wbs_dat_o[31:0]               read data (slave -> master)
interface wb_bram_ctrl_if;

   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/wb_bram_prefetch.sv
// wb_bram_prefetch: single-word read-ahead buffer for wb_bram_ctrl.
// Only built when WB_BRAM_PREFETCH_EN is defined.
//   wb_clk_i, wb_rst_n      clock, async active-low reset (clears valid)
//   clear                   drop the buffered word (bus abort)
//   load/load_addr/load_data fill the buffer from a completed prefetch read
//   wr_en/wr_addr/wr_sel/wr_data  bus write; merged into the buffer on a tag hit
//   rd_addr, match, buf_data      lookup of a read request against the buffer
`ifdef WB_BRAM_PREFETCH_EN
module wb_bram_prefetch
   import wb_bram_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_n,
   input  logic          clear,
   input  logic          load,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [3:0]    wr_sel,
   input  logic [31:0]   wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic          match,
   output logic [31:0]   buf_data
);

   logic          valid_q;
   logic [AW-1:0] tag_q;
   logic [31:0]   buf_q;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         buf_q   <= '0;
      end else if (clear) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
         tag_q   <= load_addr;
         buf_q   <= load_data;
      end else if (wr_en && valid_q && (wr_addr == tag_q)) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_sel[b]) buf_q[8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   assign match    = valid_q && (rd_addr == tag_q);
   assign buf_data = buf_q;

endmodule
`endif

// File: rtl/wb_bram_ctrl.sv
// wb_bram_ctrl: Wishbone classic slave controller for the user-area BRAM.
// Decodes the ADDR_HI window, registers each request, holds the BRAM port
// for DELAYS wait cycles, then returns a one-cycle ack with registered data.
// Ports:
//   wb_clk_i, wb_rst_n       clock, async active-low reset
//   wbs (slave modport)      Wishbone request / ack / read data
//   bram_en, bram_we[3:0]    BRAM enable and byte write strobes
//   bram_addr[AW-1:0]        BRAM word address
//   bram_wdata, bram_rdata   BRAM write / read data (rdata one cycle after en)
//   busy                     FSM not in IDLE
// Build option: WB_BRAM_PREFETCH_EN adds a read-ahead state and buffer.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for a window hit
// ST_WAIT | BRAM access in flight, counting DELAYS cycles
// ST_ACK  | ack cycle, read data presented
// ST_PREF | reading addr+1 into the prefetch buffer (prefetch builds only)
module wb_bram_ctrl
   import wb_bram_pkg::*;
#(
   parameter logic [11:0] ADDR_HI = ADDR_HI_DEF,
   parameter int          DELAYS  = 2,
   parameter int          AW      = 10
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_n,
   wb_bram_ctrl_if.slave wbs,
   output logic          bram_en,
   output logic [3:0]    bram_we,
   output logic [AW-1:0] bram_addr,
   output logic [31:0]   bram_wdata,
   input  logic [31:0]   bram_rdata,
   output logic          busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAYS);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             we_q;
   logic             ack_q;
   logic [31:0]      dat_q;

   logic             hit;
   logic [AW-1:0]    req_addr;
   logic             unused_adr;

   assign hit      = wbs.wbs_cyc_i && wbs.wbs_stb_i && (wbs.wbs_adr_i[31:20] == ADDR_HI);
   // Offset bits above the BRAM depth alias back into the array.
   assign req_addr = wbs.wbs_adr_i[AW+1:2];
   assign unused_adr = ^{wbs.wbs_adr_i[19:AW+2], wbs.wbs_adr_i[1:0]};

`ifdef WB_BRAM_PREFETCH_EN
   logic        pf_match;
   logic [31:0] pf_data;

   wb_bram_prefetch #(.AW(AW)) u_prefetch (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_n  (wb_rst_n),
      .clear     ((state == ST_WAIT) && !wbs.wbs_cyc_i),
      .load      ((state == ST_PREF) && (cnt == CNT_LAST)),
      .load_addr (bram_addr),
      .load_data (bram_rdata),
      .wr_en     ((state == ST_IDLE) && hit && wbs.wbs_we_i),
      .wr_addr   (req_addr),
      .wr_sel    (wbs.wbs_sel_i),
      .wr_data   (wbs.wbs_dat_i),
      .rd_addr   (req_addr),
      .match     (pf_match),
      .buf_data  (pf_data)
   );
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         we_q       <= 1'b0;
         ack_q      <= 1'b0;
         dat_q      <= '0;
         bram_en    <= 1'b0;
         bram_we    <= '0;
         bram_addr  <= '0;
         bram_wdata <= '0;
      end else begin
         ack_q   <= 1'b0;
         bram_we <= '0;
         case (state)
            ST_IDLE: begin
`ifdef WB_BRAM_PREFETCH_EN
               if (hit && !wbs.wbs_we_i && pf_match) begin
                  // buffered word: skip the BRAM and ack next cycle
                  we_q      <= 1'b0;
                  bram_addr <= req_addr;
                  dat_q     <= pf_data;
                  ack_q     <= 1'b1;
                  state     <= ST_ACK;
               end else
`endif
               if (hit) begin
                  we_q       <= wbs.wbs_we_i;
                  bram_addr  <= req_addr;
                  bram_wdata <= wbs.wbs_dat_i;
                  bram_en    <= 1'b1;
                  // strobe only in the first wait cycle
                  bram_we    <= wbs.wbs_we_i ? wbs.wbs_sel_i : 4'h0;
                  cnt        <= CNT_W'(1);
                  state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!wbs.wbs_cyc_i) begin
                  bram_en <= 1'b0;
                  state   <= ST_IDLE;
               end else if (cnt == CNT_LAST) begin
                  bram_en <= 1'b0;
                  ack_q   <= 1'b1;
                  if (!we_q) dat_q <= bram_rdata;
                  state   <= ST_ACK;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_ACK: begin
`ifdef WB_BRAM_PREFETCH_EN
               if (!we_q) begin
                  bram_addr <= bram_addr + AW'(1);
                  bram_en   <= 1'b1;
                  cnt       <= CNT_W'(1);
                  state     <= ST_PREF;
               end else
`endif
               state <= ST_IDLE;
            end
`ifdef WB_BRAM_PREFETCH_EN
            ST_PREF: begin
               if (cnt == CNT_LAST) begin
                  bram_en <= 1'b0;
                  state   <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`endif
            default: begin
               bram_en <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = dat_q;
   assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// tb_wb_bram_ctrl: directed self-checking bench for wb_bram_ctrl with a
// behavioural byte-writable BRAM (registered read, one cycle after enable).
module tb_wb_bram_ctrl;

   localparam int AW = 10;

   logic          clk;
   logic          rst_n;
   logic          bram_en;
   logic [3:0]    bram_we;
   logic [AW-1:0] bram_addr;
   logic [31:0]   bram_wdata;
   logic [31:0]   bram_rdata;
   logic          busy;

   logic [31:0]   mem [0:(1<<AW)-1];

   int n_chk = 0;
   int n_err = 0;

   wb_bram_ctrl_if bus ();

   wb_bram_ctrl #(.ADDR_HI(12'h380), .DELAYS(2), .AW(AW)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n   (rst_n),
      .wbs        (bus),
      .bram_en    (bram_en),
      .bram_we    (bram_we),
      .bram_addr  (bram_addr),
      .bram_wdata (bram_wdata),
      .bram_rdata (bram_rdata),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bram_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
         end
         bram_rdata <= mem[bram_addr];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = 32'h0;
      bus.wbs_dat_i = 32'h0;
   endtask

   task automatic bus_drive(input logic we, input logic [31:0] adr,
                            input logic [3:0] sel, input logic [31:0] dat);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_sel_i = sel;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = dat;
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 20; k++) begin
         if (!busy) break;
         @(posedge clk); #1;
      end
      if (k == 20) chk("wait_idle_timeout", 32'(k), 32'd0);
   endtask

   // lat = cycles from the request cycle T to the ack cycle (-1 = none)
   task automatic wb_access(input bit do_wait, input logic we, input logic [31:0] adr,
                            input logic [3:0] sel, input logic [31:0] dat,
                            output logic [31:0] rd, output int lat);
      if (do_wait) wait_idle();
      @(posedge clk); #1;
      bus_drive(we, adr, sel, dat);
      lat = -1;
      rd  = 32'hx;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.wbs_ack_o) begin
            lat = i;
            rd  = bus.wbs_dat_o;
            break;
         end
      end
      @(posedge clk); #1;
      bus_idle();
   endtask

   initial begin
      logic [31:0] rd;
      int          lat;
      logic        seen;
      int          ack_at [2];
      int          n_ack;

      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
      mem[2]  = 32'h22222222;
      mem[4]  = 32'h44440004;
      mem[5]  = 32'h55550005;
      mem[6]  = 32'h66660006;
      mem[16] = 32'h5A5A0010;
      mem[32] = 32'h77770020;
      bram_rdata = 32'h0;
      bus_idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      chk("rst_ack",   32'(bus.wbs_ack_o), 32'd0);
      chk("rst_dat",   bus.wbs_dat_o,      32'h0);
      chk("rst_en",    32'(bram_en),       32'd0);
      chk("rst_we",    32'(bram_we),       32'd0);
      chk("rst_addr",  32'(bram_addr),     32'd0);
      chk("rst_busy",  32'(busy),          32'd0);

      // full-word write, cycle by cycle
      @(posedge clk); #1;
      bus_drive(1'b1, 32'h380000A0, 4'hF, 32'hDEADBEEF);
      @(negedge clk);
      chk("w1_T_en",    32'(bram_en),  32'd0);
      @(negedge clk);
      chk("w1_T1_we",   32'(bram_we),  32'hF);
      chk("w1_T1_en",   32'(bram_en),  32'd1);
      chk("w1_T1_addr", 32'(bram_addr), 32'h28);
      chk("w1_T1_wd",   bram_wdata,    32'hDEADBEEF);
      chk("w1_T1_busy", 32'(busy),     32'd1);
      @(negedge clk);
      chk("w1_T2_we",   32'(bram_we),  32'h0);
      chk("w1_T2_en",   32'(bram_en),  32'd1);
      chk("w1_T2_ack",  32'(bus.wbs_ack_o), 32'd0);
      @(negedge clk);
      chk("w1_T3_ack",  32'(bus.wbs_ack_o), 32'd1);
      chk("w1_T3_en",   32'(bram_en),  32'd0);
      @(posedge clk); #1;
      bus_idle();
      @(negedge clk);
      chk("w1_T4_ack",  32'(bus.wbs_ack_o), 32'd0);
      chk("w1_dat_keep", bus.wbs_dat_o, 32'h0);

      wb_access(1'b1, 1'b0, 32'h380000A0, 4'hF, 32'h0, rd, lat);
      chk("r1_lat",  32'(lat), 32'd3);
      chk("r1_data", rd,       32'hDEADBEEF);

      // partial write merges into existing word
      wb_access(1'b1, 1'b1, 32'h38000004, 4'hF, 32'h11223344, rd, lat);
      chk("w2a_lat", 32'(lat), 32'd3);
      chk("w2_dat_hold", bus.wbs_dat_o, 32'hDEADBEEF);
      wb_access(1'b1, 1'b1, 32'h38000004, 4'b0010, 32'h0000AB00, rd, lat);
      chk("w2b_lat", 32'(lat), 32'd3);
      wb_access(1'b1, 1'b0, 32'h38000004, 4'hF, 32'h0, rd, lat);
      chk("r2_data", rd, 32'h1122AB44);

      // aliasing: offset bits above AW+1 wrap onto the same word
      wb_access(1'b1, 1'b0, 32'h38001004, 4'hF, 32'h0, rd, lat);
      chk("alias_data", rd, 32'h1122AB44);
      chk("alias_mem",  mem[1], 32'h1122AB44);

      // outside the window
      wait_idle();
      @(posedge clk); #1;
      bus_drive(1'b0, 32'h30000000, 4'hF, 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seen = seen | bram_en | bus.wbs_ack_o | busy;
      end
      chk("miss_quiet", 32'(seen), 32'd0);
      @(posedge clk); #1;
      bus_idle();

      // abort: cyc dropped in T+1
      wait_idle();
      @(posedge clk); #1;
      bus_drive(1'b0, 32'h38000040, 4'hF, 32'h0);
      @(posedge clk); #1;
      bus.wbs_cyc_i = 1'b0;
      seen = 1'b0;
      @(negedge clk);
      seen = seen | bus.wbs_ack_o;
      @(negedge clk);
      seen = seen | bus.wbs_ack_o;
      chk("abort_T2_en", 32'(bram_en), 32'd0);
      @(negedge clk);
      seen = seen | bus.wbs_ack_o;
      chk("abort_T3_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         seen = seen | bus.wbs_ack_o;
      end
      chk("abort_no_ack", 32'(seen), 32'd0);
      @(posedge clk); #1;
      bus_idle();
      wb_access(1'b1, 1'b0, 32'h38000040, 4'hF, 32'h0, rd, lat);
      chk("post_abort_lat",  32'(lat), 32'd3);
      chk("post_abort_data", rd,       32'h5A5A0010);

`ifndef WB_BRAM_PREFETCH_EN
      // back-to-back: strobe held after the first ack
      wait_idle();
      @(posedge clk); #1;
      bus_drive(1'b0, 32'h38000008, 4'hF, 32'h0);
      n_ack = 0;
      ack_at[0] = -1;
      ack_at[1] = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.wbs_ack_o) begin
            if (n_ack < 2) ack_at[n_ack] = i;
            n_ack++;
         end
      end
      chk("b2b_ack0", 32'(ack_at[0]), 32'd3);
      chk("b2b_ack1", 32'(ack_at[1]), 32'd7);
      chk("b2b_data", bus.wbs_dat_o,  32'h22222222);
      @(posedge clk); #1;
      bus_idle();
`endif

      // reset during WAIT
      wait_idle();
      @(posedge clk); #1;
      bus_drive(1'b0, 32'h38000080, 4'hF, 32'h0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ack",  32'(bus.wbs_ack_o), 32'd0);
      chk("rst_mid_en",   32'(bram_en),       32'd0);
      chk("rst_mid_busy", 32'(busy),          32'd0);
      chk("rst_mid_dat",  bus.wbs_dat_o,      32'h0);
      @(posedge clk); #1;
      bus_idle();
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen = seen | bus.wbs_ack_o;
      end
      chk("rst_mid_no_ack", 32'(seen), 32'd0);
      wb_access(1'b1, 1'b0, 32'h38000080, 4'hF, 32'h0, rd, lat);
      chk("post_rst_data", rd, 32'h77770020);

`ifdef WB_BRAM_PREFETCH_EN
      wb_access(1'b1, 1'b0, 32'h38000010, 4'hF, 32'h0, rd, lat);
      chk("pf_r0_lat",  32'(lat), 32'd3);
      chk("pf_r0_data", rd,       32'h44440004);
      wb_access(1'b1, 1'b0, 32'h38000014, 4'hF, 32'h0, rd, lat);
      chk("pf_r1_lat",  32'(lat), 32'd1);
      chk("pf_r1_data", rd,       32'h55550005);
      // issued in the second PREF cycle: held off until IDLE
      wb_access(1'b0, 1'b1, 32'h38000018, 4'hF, 32'hCAFEF00D, rd, lat);
      chk("pf_w_lat", 32'(lat), 32'd4);
      wb_access(1'b1, 1'b0, 32'h38000018, 4'hF, 32'h0, rd, lat);
      chk("pf_r2_lat",  32'(lat), 32'd1);
      chk("pf_r2_data", rd,       32'hCAFEF00D);
`endif

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
